// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain
//   Read-side consumer for the common FIFO. Holds off until BURST_MIN words are
//   queued, a flush is requested or TIMEOUT cycles pass. It then drains the FIFO
//   and re-presents the words as a valid/ready stream. A 2-entry skid buffer
//   absorbs the FIFO's 1-cycle read latency, so a held-high out_ready gives
//   1 word/cycle.
//
// Ports
//   clk_r         in   read-domain clock
//   rst_r         in   async active-high reset
//   fifo_empty    in   FIFO empty flag
//   fifo_occup    in   FIFO occupancy, $clog2(DEPTH)+1 bits
//   fifo_rd_data  in   FIFO read data, valid 1 cycle after fifo_rd_en
//   fifo_rd_en    out  FIFO pop request
//   flush         in   drain now regardless of BURST_MIN
//   out_valid     out  output word valid
//   out_data      out  output word (head of skid buffer)
//   out_ready     in   downstream accept
//   busy          out  FSM active, word in flight or buffer non-empty
//
// Optional build macro FIFO_RD_DRAIN_STATS_EN adds:
//   words_out     out  32-bit count of accepted output words (wraps)
//   stall_cyc     out  32-bit count of cycles with out_valid & !out_ready (wraps)
//
// state   | meaning
// S_IDLE  | FIFO empty or batch not yet started
// S_WAIT  | words queued below BURST_MIN, timeout timer running
// S_DRAIN | issuing FIFO reads under buffer credit until FIFO empty and none in flight
module fifo_rd_drain #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int BURST_MIN = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic                   clk_r,
  input  logic                   rst_r,
  input  logic                   fifo_empty,
  input  logic [$clog2(DEPTH):0] fifo_occup,
  input  logic [WIDTH-1:0]       fifo_rd_data,
  output logic                   fifo_rd_en,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic                   busy
`ifdef FIFO_RD_DRAIN_STATS_EN
  ,
  output logic [31:0]            words_out,
  output logic [31:0]            stall_cyc
`endif
);

  localparam int OW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [OW-1:0] BURST_THR  = OW'(BURST_MIN);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

  state_t           state;
  logic [TW-1:0]    timer;
  logic [1:0]       cnt;
  logic             inflight;
  logic [WIDTH-1:0] skid0;
  logic [WIDTH-1:0] skid1;
  logic             pop;
  logic             push;
  logic             occ_hit;
  logic [2:0]       fill_next;

  assign pop     = out_valid & out_ready;
  assign push    = inflight;
  assign occ_hit = (fifo_occup >= BURST_THR);

  // Buffer fill after this edge, counting the word already in flight. pop can
  // only be 1 when cnt>=1, so the subtraction never wraps.
  assign fill_next = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};

  // Kept combinational: the read must see fifo_empty and the downstream pop of
  // the same cycle to avoid empty reads and still sustain 1 word/cycle.
  assign fifo_rd_en = (state == S_DRAIN) & ~fifo_empty & (fill_next < 3'd2);

  assign out_valid = (cnt != 2'd0);
  assign out_data  = skid0;
  assign busy      = (state != S_IDLE) | (cnt != 2'd0) | inflight;

  // Timeout timer counts down from TIMEOUT-1 and fires at zero, which gives
  // exactly TIMEOUT cycles in S_WAIT.
  always_ff @(posedge clk_r or posedge rst_r) begin
    if (rst_r) begin
      state    <= S_IDLE;
      timer    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            if (occ_hit || flush) begin
              state <= S_DRAIN;
            end else begin
              state <= S_WAIT;
              timer <= TIMER_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (fifo_empty) begin
            state <= S_IDLE;
          end else if (occ_hit || flush || (timer == '0)) begin
            state <= S_DRAIN;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_DRAIN: begin
          if (fifo_empty && !inflight) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // skid0 is always the head. The credit rule guarantees no push into a full buffer.
  always_ff @(posedge clk_r or posedge rst_r) begin
    if (rst_r) begin
      cnt   <= 2'd0;
      skid0 <= '0;
      skid1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            skid0 <= fifo_rd_data;
          end else begin
            skid1 <= fifo_rd_data;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          skid0 <= skid1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            skid0 <= fifo_rd_data;
          end else begin
            skid0 <= skid1;
            skid1 <= fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_RD_DRAIN_STATS_EN
  always_ff @(posedge clk_r or posedge rst_r) begin
    if (rst_r) begin
      words_out <= 32'd0;
      stall_cyc <= 32'd0;
    end else begin
      if (pop) begin
        words_out <= words_out + 32'd1;
      end
      if (out_valid && !out_ready) begin
        stall_cyc <= stall_cyc + 32'd1;
      end
    end
  end
`endif

endmodule
